// File: rtl/line_fill_memory.sv
// line_fill_memory: backing-store responder for a direct-mapped cache miss path.
// Accepts one line fill (read) or line write-back (write) at a time, waits a
// fixed access latency, then streams one word per cycle for a whole line.
// Owns the main-memory array, which starts zeroed and is never cleared by rst.
// Optional completion counters are enabled by defining LINE_FILL_MEMORY_STATS_EN.
module line_fill_memory #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WORDS = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic                          req_wr,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [WORD_SIZE-1:0]          wr_data,
  output logic                          busy,
  output logic                          rd_valid,
  output logic [WORD_SIZE-1:0]          rd_data,
  output logic                          wr_ready,
  output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
  output logic                          done
`ifdef LINE_FILL_MEMORY_STATS_EN
  ,
  output logic [31:0]                   stat_fills,
  output logic [31:0]                   stat_writebacks
`endif
);

  localparam int BW     = $clog2(LINE_WORDS);
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int LAT_W  = $clog2(LATENCY + 1);

  localparam logic [BW-1:0]     BEAT_LAST = BW'(LINE_WORDS - 1);
  localparam logic [MEM_AW-1:0] LINE_MASK = MEM_AW'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [MEM_AW-1:0]     base_q, base_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [WORD_SIZE-1:0]  rd_data_q, rd_data_d;

  logic [WORD_SIZE-1:0]  mem [MEM_DEPTH] = '{default: '0};

  logic                  mem_we;
  logic [MEM_AW-1:0]     wr_addr;
  logic [MEM_AW-1:0]     rd_addr;
  logic [BW-1:0]         rd_beat;

  // Read data is registered, so we fetch the beat that will be shown next
  // cycle: beat 0 on the last WAIT cycle, beat+1 while bursting. The base is
  // line-aligned and beats stay below LINE_WORDS, so no line crossing occurs.
  assign rd_beat = (state_q == S_WAIT) ? '0 : beat_q + BW'(1);
  assign rd_addr = base_q + MEM_AW'(rd_beat);
  assign wr_addr = base_q + MEM_AW'(beat_q);

  // A beat being written at an edge with rst high is dropped (abort).
  assign mem_we  = (state_q == S_BURST) && wr_q && !rst;

  // State register plus captured request, counters and read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      base_q    <= '0;
      cnt_q     <= '0;
      beat_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next-state: latency countdown in WAIT, one beat per cycle in BURST.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_BURST;
      S_BURST: if (beat_q == BEAT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: request capture, countdown, beat index, read fetch.
  always_comb begin
    wr_d      = wr_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    beat_d    = '0;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d   = req_wr;
          base_d = MEM_AW'(req_addr) & ~LINE_MASK;
          cnt_d  = LAT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end else if (!wr_q) begin
          rd_data_d = mem[rd_addr];
        end
      end
      S_BURST: begin
        if (beat_q != BEAT_LAST) begin
          beat_d = beat_q + BW'(1);
          if (!wr_q) rd_data_d = mem[rd_addr];
        end
      end
      default: ;
    endcase
  end

  // Memory write port: one write-back beat per BURST cycle.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

  // Outputs decoded from the current state; rd_data holds between fills.
  always_comb begin
    busy     = (state_q != S_IDLE);
    rd_valid = (state_q == S_BURST) && !wr_q;
    wr_ready = (state_q == S_BURST) && wr_q;
    done     = (state_q == S_DONE);
    beat_idx = beat_q;
    rd_data  = rd_data_q;
  end

`ifdef LINE_FILL_MEMORY_STATS_EN
  logic [31:0] stat_fills_q, stat_fills_d;
  logic [31:0] stat_wbs_q, stat_wbs_d;

  // Count each transaction type on its DONE cycle; aborted ones never get there.
  always_comb begin
    stat_fills_d = stat_fills_q;
    stat_wbs_d   = stat_wbs_q;
    if (state_q == S_DONE) begin
      if (wr_q) stat_wbs_d   = stat_wbs_q + 32'd1;
      else      stat_fills_d = stat_fills_q + 32'd1;
    end
  end

  // Completion counters, cleared by rst and wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fills_q <= '0;
      stat_wbs_q   <= '0;
    end else begin
      stat_fills_q <= stat_fills_d;
      stat_wbs_q   <= stat_wbs_d;
    end
  end

  assign stat_fills      = stat_fills_q;
  assign stat_writebacks = stat_wbs_q;
`endif

endmodule

// File: tb/tb_line_fill_memory.sv
// tb_line_fill_memory: directed and randomized transactions against a simple
// array model of the backing store and a cycle-count model of the protocol.
module tb_line_fill_memory;

  localparam int WS  = 32;
  localparam int AW  = 16;
  localparam int LW  = 4;
  localparam int MD  = 1024;
  localparam int LAT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [WS-1:0] wr_data;
  logic          busy;
  logic          rd_valid;
  logic [WS-1:0] rd_data;
  logic          wr_ready;
  logic [1:0]    beat_idx;
  logic          done;
`ifdef LINE_FILL_MEMORY_STATS_EN
  logic [31:0]   stat_fills;
  logic [31:0]   stat_writebacks;
`endif

  int total = 0;
  int bad   = 0;

  logic [WS-1:0] ref_mem [MD];
  logic [WS-1:0] wbuf [LW];
  int exp_fills = 0;
  int exp_wbs   = 0;

  line_fill_memory #(
    .WORD_SIZE (WS),
    .ADDR_WIDTH(AW),
    .LINE_WORDS(LW),
    .MEM_DEPTH (MD),
    .LATENCY   (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_ready (wr_ready),
    .beat_idx (beat_idx),
    .done     (done)
`ifdef LINE_FILL_MEMORY_STATS_EN
    ,
    .stat_fills      (stat_fills),
    .stat_writebacks (stat_writebacks)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word address of beat b of the line containing addr, in the memory's range.
  function automatic int line_addr(input int addr, input int b);
    return ((addr / LW) * LW + b) % MD;
  endfunction

  task automatic chk_stats(input string tag);
`ifdef LINE_FILL_MEMORY_STATS_EN
    chk({tag, "_fills"}, stat_fills, exp_fills);
    chk({tag, "_wbs"}, stat_writebacks, exp_wbs);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One whole transaction. Control outputs are checked as the vector
  // {busy, rd_valid, wr_ready, done, beat_idx}.
  task automatic txn(input bit wr, input logic [AW-1:0] addr, input bit keep_req,
                     input bit inject, input int abort_at);
    int a;
    req      = 1'b1;
    req_wr   = wr;
    req_addr = addr;
    step();
    if (!keep_req) req = 1'b0;
    req_addr = AW'($urandom);
    req_wr   = ~wr;
    for (int w = 0; w < LAT; w++) begin
      chk("wait_ctl", {busy, rd_valid, wr_ready, done, beat_idx}, 6'b100000);
      if (inject && w == 2) begin
        req      = 1'b1;
        req_addr = 16'h0040;
      end
      if (inject && w == 3) req = 1'b0;
      step();
    end
    for (int b = 0; b < LW; b++) begin
      a = line_addr(int'(addr), b);
      if (wr) begin
        wr_data = wbuf[b];
        chk("wb_ctl", {busy, rd_valid, wr_ready, done, beat_idx}, {4'b1010, 2'(b)});
      end else begin
        chk("rd_ctl", {busy, rd_valid, wr_ready, done, beat_idx}, {4'b1100, 2'(b)});
        chk("rd_data", rd_data, ref_mem[a]);
      end
      if (b == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_fills = 0;
        exp_wbs   = 0;
        chk("abort_ctl", {busy, rd_valid, wr_ready, done, beat_idx}, 6'b000000);
        chk("abort_rdata", rd_data, 0);
        chk_stats("abort_stat");
        return;
      end
      step();
      if (wr) ref_mem[a] = wbuf[b];
    end
    chk("done_ctl", {busy, rd_valid, wr_ready, done, beat_idx}, 6'b100100);
    step();
    if (wr) exp_wbs++;
    else    exp_fills++;
    chk("post_ctl", {busy, rd_valid, wr_ready, done, beat_idx}, 6'b000000);
    if (!wr) chk("rd_hold", rd_data, ref_mem[line_addr(int'(addr), LW - 1)]);
    chk_stats("post_stat");
  endtask

  initial begin
    bit            rwr;
    bit            rkeep;
    logic [AW-1:0] raddr;

    rst      = 1'b1;
    req      = 1'b0;
    req_wr   = 1'b0;
    req_addr = '0;
    wr_data  = '0;
    for (int i = 0; i < MD; i++) ref_mem[i] = '0;
    step();
    step();
    chk("reset_ctl", {busy, rd_valid, wr_ready, done, beat_idx}, 6'b000000);
    chk("reset_rdata", rd_data, 0);
    chk_stats("reset_stat");
    rst = 1'b0;
    step();
    step();
    chk("idle_noreq", {busy, rd_valid, wr_ready, done, beat_idx}, 6'b000000);

    // Fill of a zeroed line straight after reset.
    txn(1'b0, 16'h0000, 1'b0, 1'b0, -1);

    // Write-back to 0x13 lands in line 0x10..0x13, then read it back.
    for (int b = 0; b < LW; b++) wbuf[b] = WS'(32'hA0 + b);
    txn(1'b1, 16'h0013, 1'b0, 1'b0, -1);
    txn(1'b0, 16'h0010, 1'b0, 1'b0, -1);
    chk("line10_beat0", ref_mem[16], 32'hA0);
    chk("line10_beat3", ref_mem[19], 32'hA3);

    // A request pulse during WAIT must not start a second transaction.
    txn(1'b0, 16'h0010, 1'b0, 1'b1, -1);
    step();
    chk("ignored_req_idle", {busy, done}, 2'b00);

    // Aliasing: 0x0410 maps onto line 0x010.
    txn(1'b0, 16'h0410, 1'b0, 1'b0, -1);

    // req held high: back-to-back transactions with one idle cycle between.
    for (int b = 0; b < LW; b++) wbuf[b] = $urandom;
    txn(1'b1, 16'h0020, 1'b1, 1'b0, -1);
    txn(1'b0, 16'h0021, 1'b1, 1'b0, -1);
    txn(1'b0, 16'h0012, 1'b0, 1'b0, -1);

    // Write-back to line 0x10 aborted by rst on beat 2: beats 0-1 only.
    for (int b = 0; b < LW; b++) wbuf[b] = WS'(32'hB0 + b);
    txn(1'b1, 16'h0010, 1'b0, 1'b0, 2);
    txn(1'b0, 16'h0010, 1'b0, 1'b0, -1);

    // Randomized mix of fills and write-backs over a small aliased region.
    for (int i = 0; i < 24; i++) begin
      rwr   = 1'(($urandom_range(0, 1)));
      rkeep = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      raddr = AW'($urandom_range(0, 63)) | (AW'($urandom_range(0, 63)) << 10);
      for (int b = 0; b < LW; b++) wbuf[b] = $urandom;
      txn(rwr, raddr, rkeep, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_fill_memory.md
Name: line_fill_memory

Overview:
- Backing-store responder for the direct-mapped cache's miss path.
- The cache initiates line fills (reads) and line write-backs (writes). This block answers them after a fixed access latency, transferring one word per cycle for a full line.
- Owns the main-memory array.
- Used as the cache's downstream partner in simulation and as a model of the external memory port.

Parameters:
- WORD_SIZE, 32, data word width in bits.
- ADDR_WIDTH, 16, word-address width of the request.
- LINE_WORDS, 4, words per cache line; power of two, >= 2.
- MEM_DEPTH, 1024, memory size in words; power of two.
- LATENCY, 8, cycles spent in WAIT before the first beat; >= 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- req_wr  in  1  1 = line write-back, 0 = line fill; sampled with req.
- req_addr  in  ADDR_WIDTH  word address; low log2(LINE_WORDS) bits ignored (line-aligned).
- wr_data  in  WORD_SIZE  write beat data; must correspond to beat_idx while wr_ready=1.
- busy  out  1  high in WAIT, BURST and DONE.
- rd_valid  out  1  read beat valid.
- rd_data  out  WORD_SIZE  read beat data.
- wr_ready  out  1  write beat consumed this cycle.
- beat_idx  out  log2(LINE_WORDS)  current beat number within the line.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: synchronous. At any edge with rst=1:
  - state goes to IDLE; busy, rd_valid, wr_ready, done, beat_idx and rd_data all go to 0.
  - Any in-flight transaction is aborted; a partially written line keeps the beats already written.
  - Memory contents are not cleared by rst; the array is zero-initialised at time 0.
- FSM states: IDLE, WAIT, BURST, DONE.
- IDLE:
  - On req=1, capture req_wr and the line base (req_addr with low bits cleared, modulo MEM_DEPTH).
  - Load the latency counter with LATENCY-1 and go to WAIT.
  - req=0 stays in IDLE.
- WAIT: counter decrements each cycle; at 0, go to BURST with beat_idx=0. Exactly LATENCY cycles are spent in WAIT.
- BURST: lasts LINE_WORDS cycles; beat_idx = 0..LINE_WORDS-1.
  - Read: rd_valid=1 and rd_data = mem[base+beat_idx] for that cycle. Outputs are registered, so the first beat is visible on the cycle after the last WAIT cycle.
  - Write: wr_ready=1; at the edge ending the cycle, mem[base+beat_idx] <= wr_data.
  - After beat LINE_WORDS-1, go to DONE.
- DONE: done=1 and busy=1 for one cycle; then IDLE, with busy=0.
- Latency: with req accepted at edge E0, beat 0 is presented in the cycle following edge E0+LATENCY. done is high in the cycle following edge E0+LATENCY+LINE_WORDS. The earliest next acceptance is the edge after that.
- Request handling:
  - The request is captured at acceptance.
  - req, req_wr and req_addr changes while busy are ignored; req held high while busy does not queue a second transaction.
  - req held high through DONE is accepted again in IDLE.
- Address arithmetic:
  - Beat address = (base + beat_idx) mod MEM_DEPTH.
  - req_addr bits above log2(MEM_DEPTH) are ignored, so addresses alias.
  - Beats never cross a line boundary.
- Outputs outside their states: rd_valid=0 and wr_ready=0; rd_data holds its last value; beat_idx=0 outside BURST.

Optional Feature:
- Macro: LINE_FILL_MEMORY_STATS_EN.
- When defined, the block adds ports:
  - stat_fills  out 32  count of completed line fills.
  - stat_writebacks  out 32  count of completed write-backs.
- Counter rules:
  - Each counter increments on the DONE cycle of its transaction type.
  - Counters clear on rst and wrap at 2^32.
  - Aborted transactions are not counted.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Fill after reset: req=1, req_wr=0, req_addr=0x0000 → busy rises next cycle; 8 WAIT cycles; 4 beats with rd_valid=1, rd_data=0, beat_idx=0,1,2,3; done pulses once; busy then falls.
- Write-back then fill: write to req_addr=0x0013 with wr_data = 0xA0+beat_idx → mem[0x10..0x13] = 0xA0..0xA3. A subsequent fill of 0x0010 returns 0xA0,0xA1,0xA2,0xA3 in beat order.
- Ignored request: pulse req with req_addr=0x0040 during WAIT of a fill to 0x0010 → no second transaction; returned data belongs to line 0x10.
- Back-to-back requests: hold req=1 continuously → accepted on the edge after done falls; exactly one done per transaction; no overlap.
- Aliasing and mid-burst reset:
  - Fill of 0x0410 with MEM_DEPTH=1024 returns the line at 0x0010.
  - Assert rst during write-back beat 2 → outputs are 0 the next cycle; beats 0-1 are written and beats 2-3 are unchanged.
- With LINE_FILL_MEMORY_STATS_EN defined: 2 fills, 1 write-back, then 1 write-back aborted by rst → stat_fills=0, stat_writebacks=0 after rst. Before the rst, stat_fills=2 and stat_writebacks=1.
